flash_detect: RTL and testbench

//  Receive-side counterpart of the lamp flasher: samples an external blinking line F_IN.

---
 rtl/flash_pkg.sv | 19 +
 rtl/flash_sync.sv | 44 ++++
 rtl/flash_detect.sv | 107 ++++++++++
 tb/tb_flash_detect.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared types and default timing for the lamp flasher and its receive-side detector.
package flash_pkg;

    typedef enum logic [1:0] {
        FD_IDLE    = 2'd0,
        FD_ACQUIRE = 2'd1,
        FD_LOCKED  = 2'd2
    } fd_state_t;

    localparam int FD_CNT_W    = 16;
    localparam int FD_HALF_MIN = 4;
    localparam int FD_HALF_MAX = 8;
    localparam int FD_LOCK_CNT = 3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/flash_sync.sv
// Two-flop synchronizer for the observed flashing line.
// FLASH_DET_DEGLITCH_EN adds a registered 3-sample majority filter (+2 cycles, kills 1-cycle pulses).
module flash_sync
    import flash_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic f_i,
    output logic s_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= f_i;
            sync_q <= meta_q;
        end
    end

`ifdef FLASH_DET_DEGLITCH_EN
    logic [1:0] hist_q;
    logic       filt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist_q <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_q};
            filt_q <= maj3(sync_q, hist_q[0], hist_q[1]);
        end
    end

    assign s_o = filt_q;
`else
    assign s_o = sync_q;
`endif

endmodule

// File: rtl/flash_detect.sv
// Flashing-line detector: times half-periods of F_IN and reports lock when LOCK_CNT in a row fit.
// Optional input deglitch filter is enabled with FLASH_DET_DEGLITCH_EN (see flash_sync).
module flash_detect
    import flash_pkg::*;
#(
    parameter int CNT_W    = FD_CNT_W,
    parameter int HALF_MIN = FD_HALF_MIN,
    parameter int HALF_MAX = FD_HALF_MAX,
    parameter int LOCK_CNT = FD_LOCK_CNT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             f_in_i,
    output logic             flsh_o,
    output logic             level_o,
    output logic             edge_o,
    output logic [CNT_W-1:0] half_len_o
);

    localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    logic             s;
    logic             s_prev_q;
    logic             edge_det;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] meas;
    logic             meas_ok;
    logic             timeout;
    logic             lock_hit;
    fd_state_t        state_q;
    logic [GOOD_W-1:0] good_q;
    logic             flsh_q;
    logic [CNT_W-1:0] half_len_q;

    flash_sync u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .f_i     (f_in_i),
        .s_o     (s)
    );

    assign edge_det = s ^ s_prev_q;
    // meas doubles as the saturating increment of the half-period counter
    assign meas     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign meas_ok  = (meas >= CNT_W'(HALF_MIN)) && (meas <= CNT_W'(HALF_MAX));
    assign timeout  = !edge_det && (cnt_q == CNT_W'(HALF_MAX));
    assign lock_hit = (int'(good_q) + 1 == LOCK_CNT);
    assign cnt_d    = edge_det ? '0 : meas;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s_prev_q   <= 1'b0;
            cnt_q      <= '0;
            state_q    <= FD_IDLE;
            good_q     <= '0;
            flsh_q     <= 1'b0;
            half_len_q <= '0;
        end else begin
            s_prev_q <= s;
            cnt_q    <= cnt_d;
            if (edge_det) begin
                half_len_q <= meas;
                case (state_q)
                    FD_IDLE: begin
                        state_q <= FD_ACQUIRE;
                        good_q  <= '0;
                        flsh_q  <= 1'b0;
                    end
                    FD_ACQUIRE: begin
                        if (!meas_ok) begin
                            good_q <= '0;
                        end else if (lock_hit) begin
                            state_q <= FD_LOCKED;
                            good_q  <= '0;
                            flsh_q  <= 1'b1;
                        end else begin
                            good_q <= good_q + 1'b1;
                        end
                    end
                    FD_LOCKED: begin
                        if (!meas_ok) begin
                            state_q <= FD_ACQUIRE;
                            good_q  <= '0;
                            flsh_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= FD_IDLE;
                        good_q  <= '0;
                        flsh_q  <= 1'b0;
                    end
                endcase
            end else if (timeout) begin
                state_q <= FD_IDLE;
                good_q  <= '0;
                flsh_q  <= 1'b0;
            end
        end
    end

    assign flsh_o     = flsh_q;
    assign level_o    = s;
    assign edge_o     = edge_det;
    assign half_len_o = half_len_q;

endmodule

// File: tb/tb_flash_detect.sv
// Directed bench for flash_detect at default timing (HALF_MIN=4, HALF_MAX=8, LOCK_CNT=3).
module tb_flash_detect;

`ifdef FLASH_DET_DEGLITCH_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        f_in;
    logic        flsh;
    logic        level;
    logic        edge_p;
    logic [15:0] half_len;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;
    int e0;

    flash_detect dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .f_in_i     (f_in),
        .flsh_o     (flsh),
        .level_o    (level),
        .edge_o     (edge_p),
        .half_len_o (half_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (edge_p === 1'b1) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %0d exp %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_halves(input int n, input int k);
        repeat (k) begin
            f_in = ~f_in;
            tick(n);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        f_in  = 1'b0;
        tick(3);
        check("rst_flsh", 32'(flsh), 0);
        check("rst_level", 32'(level), 0);
        check("rst_edge", 32'(edge_p), 0);
        check("rst_half_len", 32'(half_len), 0);
        rst_n = 1'b1;
        tick(12);

        // 1: half-period 6, lock after the 4th edge
        e0 = edge_cnt;
        run_halves(6, 3);
        check("t1_flsh_3e", 32'(flsh), 0);
        run_halves(6, 1);
        check("t1_flsh_4e", 32'(flsh), 1);
        check("t1_edges", 32'(edge_cnt - e0), 4);
        run_halves(6, 4);
        check("t1_flsh_hold", 32'(flsh), 1);
        check("t1_half_len", 32'(half_len), 6);
        check("t1_level", 32'(level), 32'(f_in));

        // 2: stop toggling high, timeout exactly when cnt reaches HALF_MAX
        f_in = 1'b1;
        tick(11 + LAT);
        check("t2_pre_tmo", 32'(flsh), 1);
        tick(1);
        check("t2_timeout", 32'(flsh), 0);
        tick(8);
        check("t2_level", 32'(level), 1);
        check("t2_half_len", 32'(half_len), 6);

        // 3: relock, one short half drops lock, three valid halves relock
        run_halves(6, 4);
        check("t3_lock", 32'(flsh), 1);
        run_halves(2, 1);
        run_halves(6, 1);
        check("t3_short_drop", 32'(flsh), 0);
        check("t3_half_len", 32'(half_len), 2);
        run_halves(6, 2);
        check("t3_two_valid", 32'(flsh), 0);
        run_halves(6, 1);
        check("t3_relock", 32'(flsh), 1);

        // 4: 9-cycle halves never lock; 4 and 8 are inclusive bounds
        run_halves(9, 6);
        check("t4_nine_flsh", 32'(flsh), 0);
        check("t4_nine_len", 32'(half_len), 9);
        run_halves(4, 5);
        check("t4_four_lock", 32'(flsh), 1);
        check("t4_four_len", 32'(half_len), 4);
        run_halves(8, 5);
        check("t4_eight_lock", 32'(flsh), 1);
        check("t4_eight_len", 32'(half_len), 8);

        // 5: asynchronous reset mid-cycle while locked
        #3;
        rst_n = 1'b0;
        f_in  = 1'b0;
        #1;
        check("t5_flsh", 32'(flsh), 0);
        check("t5_edge", 32'(edge_p), 0);
        check("t5_half_len", 32'(half_len), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        run_halves(6, 3);
        check("t5_three_e", 32'(flsh), 0);
        run_halves(6, 1);
        check("t5_relock", 32'(flsh), 1);

        // 6: single-cycle glitch
        e0 = edge_cnt;
        f_in = ~f_in;
        tick(1);
        f_in = ~f_in;
        tick(4);
`ifdef FLASH_DET_DEGLITCH_EN
        check("t6_edges", 32'(edge_cnt - e0), 0);
        check("t6_flsh", 32'(flsh), 1);
        check("t6_half_len", 32'(half_len), 6);
`else
        check("t6_edges", 32'(edge_cnt - e0), 2);
        check("t6_flsh", 32'(flsh), 0);
        check("t6_half_len", 32'(half_len), 1);
`endif
        check("t6_level", 32'(level), 32'(f_in));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
